// File: rtl/packetizer_seq.sv
// packetizer_seq: acquisition sequencer for the ADC packetizer S2MM path.
// Programs the packetizer length register, brackets each acquisition with a
// packetizer reset, issues one DataMover S2MM command per packet into a ring
// buffer, counts completed packets and pulses an interrupt on completion.
module packetizer_seq #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int DRAIN_TIMEOUT   = 1024
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] packet_len,
   input  logic [31:0] num_packets,
   input  logic [31:0] base_addr,
   input  logic [15:0] ring_packets,
   output logic [31:0] pkt_config,
   output logic        pkt_resetn,
   input  logic        pkt_done,
   output logic [63:0] m_axis_cmd_tdata,
   output logic        m_axis_cmd_tvalid,
   input  logic        m_axis_cmd_tready,
   output logic        busy,
   output logic        irq,
   output logic [31:0] packets_done,
   output logic        err,
   output logic [2:0]  state
);

   localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_FLUSH = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t          r_state;
   state_t          w_state_nx;
   logic            w_start_ok;

   // Parameters latched on an accepted start
   logic [15:0]     r_len;
   logic [31:0]     r_num;
   logic [31:0]     r_base;
   logic [15:0]     r_ring;

   // Acquisition bookkeeping
   logic [31:0]     r_issued;
   logic [31:0]     r_done;
   logic [15:0]     r_slot;
   logic [31:0]     r_off;
   logic            r_arm_cnt;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_drain_seen;
   logic            r_err;

   // Registered outputs
   logic [63:0]     r_tdata;
   logic            r_tvalid;
   logic [31:0]     r_cfg;
   logic            r_prstn;
   logic            r_busy;
   logic            r_irq;

   logic            w_accept;
   logic            w_cnt_done;
   logic            w_pend_clear;
   logic            w_slot_wrap;
   logic [31:0]     w_bytes;
   logic [31:0]     w_issued_nx;
   logic [31:0]     w_done_nx;
   logic [15:0]     w_slot_nx;
   logic [31:0]     w_off_nx;
   logic [31:0]     w_out_cur;
   logic [31:0]     w_out_nx;
   logic [63:0]     w_tdata_nx;
   logic            w_tvalid_nx;
   logic [31:0]     w_cfg_nx;
   logic            w_prstn_nx;

   // Post-edge view of the counters, so a new command can follow an accept
   // on the very next cycle and accept+done in one cycle nets out.
   always_comb begin
      w_accept     = r_tvalid & m_axis_cmd_tready;
      w_pend_clear = ~r_tvalid | m_axis_cmd_tready;
      w_cnt_done   = pkt_done & ((r_state == S_RUN) | (r_state == S_DRAIN));
      w_bytes      = {14'd0, r_len, 2'd0};
      w_slot_wrap  = (r_ring != 16'd0) && ((r_slot + 16'd1) == r_ring);
      w_issued_nx  = r_issued + {31'd0, w_accept};
      w_done_nx    = r_done + {31'd0, w_cnt_done};
      w_out_cur    = r_issued - r_done;
      w_out_nx     = w_issued_nx - w_done_nx;
      w_slot_nx    = r_slot;
      w_off_nx     = r_off;
      if (w_accept) begin
         if (w_slot_wrap) begin
            w_slot_nx = 16'd0;
            w_off_nx  = 32'd0;
         end else begin
            w_slot_nx = r_slot + 16'd1;
            w_off_nx  = r_off + w_bytes;
         end
      end
   end

   // Next-state and next-output decode
   always_comb begin
      w_state_nx  = r_state;
      w_start_ok  = 1'b0;
      w_tvalid_nx = 1'b0;
      w_tdata_nx  = r_tdata;
      w_cfg_nx    = 32'd0;
      w_prstn_nx  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && (packet_len != 16'd0)) begin
               w_state_nx = S_ARM;
               w_start_ok = 1'b1;
            end
         end
         S_ARM: begin
            if (r_arm_cnt) w_state_nx = S_RUN;
         end
         S_RUN: begin
            // Completion outranks a coincident stop
            if ((r_num != 32'd0) && (w_done_nx == r_num)) w_state_nx = S_DONE;
            else if (stop)                                 w_state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            // Never leave while a command is still waiting for tready
            if (w_pend_clear) begin
               if (r_drain_seen || pkt_done || (w_out_nx == 32'd0)) w_state_nx = S_DONE;
               else if (r_to_cnt == TO_LAST)                        w_state_nx = S_FLUSH;
            end
         end
         S_FLUSH: w_state_nx = S_DONE;
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase

      if ((w_state_nx == S_RUN) || (w_state_nx == S_DRAIN)) begin
         w_cfg_nx   = {16'd0, r_len};
         w_prstn_nx = 1'b1;
      end

      if (r_tvalid && !m_axis_cmd_tready) begin
         w_tvalid_nx = 1'b1;
      end else if ((w_state_nx == S_RUN) &&
                   (w_out_nx < 32'(MAX_OUTSTANDING)) &&
                   ((r_num == 32'd0) || (w_issued_nx < r_num))) begin
         w_tvalid_nx = 1'b1;
         w_tdata_nx  = {w_issued_nx[7:0], w_bytes[23:0], r_base + w_off_nx};
      end
   end

   // State register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= S_IDLE;
      else          r_state <= w_state_nx;
   end

   // Latched parameters, counters and registered outputs
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_len        <= 16'd0;
         r_num        <= 32'd0;
         r_base       <= 32'd0;
         r_ring       <= 16'd0;
         r_issued     <= 32'd0;
         r_done       <= 32'd0;
         r_slot       <= 16'd0;
         r_off        <= 32'd0;
         r_arm_cnt    <= 1'b0;
         r_to_cnt     <= '0;
         r_drain_seen <= 1'b0;
         r_err        <= 1'b0;
         r_tdata      <= 64'd0;
         r_tvalid     <= 1'b0;
         r_cfg        <= 32'd0;
         r_prstn      <= 1'b0;
         r_busy       <= 1'b0;
         r_irq        <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_len    <= packet_len;
            r_num    <= num_packets;
            r_base   <= base_addr;
            r_ring   <= ring_packets;
            r_issued <= 32'd0;
            r_done   <= 32'd0;
            r_slot   <= 16'd0;
            r_off    <= 32'd0;
            r_err    <= 1'b0;
         end else begin
            r_issued <= w_issued_nx;
            r_done   <= w_done_nx;
            r_slot   <= w_slot_nx;
            r_off    <= w_off_nx;
            if (pkt_done && (w_out_cur == 32'd0)) r_err <= 1'b1;
         end

         r_arm_cnt <= (r_state == S_ARM) ? ~r_arm_cnt : 1'b0;

         if (r_state == S_DRAIN) begin
            if (r_to_cnt != TO_LAST) r_to_cnt <= r_to_cnt + 1'b1;
            if (pkt_done)            r_drain_seen <= 1'b1;
         end else begin
            r_to_cnt     <= '0;
            r_drain_seen <= 1'b0;
         end

         r_tdata  <= w_tdata_nx;
         r_tvalid <= w_tvalid_nx;
         r_cfg    <= w_cfg_nx;
         r_prstn  <= w_prstn_nx;
         r_busy   <= (w_state_nx != S_IDLE);
         r_irq    <= (w_state_nx == S_DONE);
      end
   end

   assign state             = r_state;
   assign pkt_config        = r_cfg;
   assign pkt_resetn        = r_prstn;
   assign m_axis_cmd_tdata  = r_tdata;
   assign m_axis_cmd_tvalid = r_tvalid;
   assign busy              = r_busy;
   assign irq               = r_irq;
   assign packets_done      = r_done;
   assign err               = r_err;

endmodule

// File: tb/tb_packetizer_seq.sv
// Directed testbench for packetizer_seq.
module tb_packetizer_seq;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        start, stop, pkt_done, tready;
   logic [15:0] packet_len, ring_packets;
   logic [31:0] num_packets, base_addr;
   logic [31:0] pkt_config, packets_done;
   logic        pkt_resetn, tvalid, busy, irq, err;
   logic [63:0] tdata;
   logic [2:0]  state;

   int n_chk = 0;
   int n_err = 0;

   logic [63:0] cmds[$];
   int irq_cnt, drain_cycles, flush_cycles, flush_ok;

   packetizer_seq #(.MAX_OUTSTANDING(4), .DRAIN_TIMEOUT(1024)) dut (
      .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
      .packet_len(packet_len), .num_packets(num_packets), .base_addr(base_addr),
      .ring_packets(ring_packets), .pkt_config(pkt_config), .pkt_resetn(pkt_resetn),
      .pkt_done(pkt_done), .m_axis_cmd_tdata(tdata), .m_axis_cmd_tvalid(tvalid),
      .m_axis_cmd_tready(tready), .busy(busy), .irq(irq), .packets_done(packets_done),
      .err(err), .state(state)
   );

   always #5 aclk = ~aclk;

   // Observe accepted commands and status pulses mid-cycle
   always @(negedge aclk) begin
      if (tvalid && tready) cmds.push_back(tdata);
      if (irq) irq_cnt++;
      if (state == 3'd3) drain_cycles++;
      if (state == 3'd4) begin
         flush_cycles++;
         if (!pkt_resetn && pkt_config == 32'd0) flush_ok++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_done();
      pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
      tick();
   endtask

   function automatic logic [63:0] cmd(input logic [7:0] tag, input logic [31:0] addr);
      return {tag, 24'd40, addr};
   endfunction

   task automatic clr_mon();
      cmds.delete();
      irq_cnt = 0;
      drain_cycles = 0;
      flush_cycles = 0;
      flush_ok = 0;
   endtask

   initial begin
      aresetn = 1'b0; start = 0; stop = 0; pkt_done = 0; tready = 1;
      packet_len = 16'd10; num_packets = 32'd3; base_addr = 32'h1000_0000; ring_packets = 16'd0;
      clr_mon();
      repeat (3) tick();
      chk("rst_state", state, 0);
      chk("rst_cfg", pkt_config, 0);
      chk("rst_prstn", pkt_resetn, 0);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_irq", irq, 0);
      chk("rst_pdone", packets_done, 0);
      chk("rst_err", err, 0);
      aresetn = 1'b1;
      tick();

      // Three packets, no wrap; last done coincides with stop
      clr_mon();
      pulse_start();
      chk("t1_arm", state, 1);
      chk("t1_busy", busy, 1);
      chk("t1_arm_prstn", pkt_resetn, 0);
      tick();
      chk("t1_arm2", state, 1);
      tick();
      chk("t1_run", state, 2);
      chk("t1_prstn", pkt_resetn, 1);
      chk("t1_cfg", pkt_config, 10);
      chk("t1_tvalid", tvalid, 1);
      chk("t1_first", tdata, cmd(8'd0, 32'h1000_0000));
      repeat (5) tick();
      chk("t1_ncmd", cmds.size(), 3);
      if (cmds.size() == 3) begin
         chk("t1_c0", cmds[0], cmd(8'd0, 32'h1000_0000));
         chk("t1_c1", cmds[1], cmd(8'd1, 32'h1000_0028));
         chk("t1_c2", cmds[2], cmd(8'd2, 32'h1000_0050));
      end
      chk("t1_tv_off", tvalid, 0);
      pulse_done();
      pulse_done();
      chk("t1_pd2", packets_done, 2);
      pkt_done = 1'b1; stop = 1'b1;
      tick();
      pkt_done = 1'b0; stop = 1'b0;
      chk("t1_done_st", state, 5);
      chk("t1_irq", irq, 1);
      tick();
      chk("t1_idle", state, 0);
      chk("t1_irq_cnt", irq_cnt, 1);
      chk("t1_pdone", packets_done, 3);
      chk("t1_no_drain", drain_cycles, 0);

      // Stray packet boundary with nothing outstanding
      pulse_done();
      chk("err_set", err, 1);

      // Four packets, ring of two
      clr_mon();
      num_packets = 32'd4; ring_packets = 16'd2;
      pulse_start();
      chk("t2_err_clr", err, 0);
      repeat (8) tick();
      chk("t2_ncmd", cmds.size(), 4);
      if (cmds.size() == 4) begin
         chk("t2_c0", cmds[0], cmd(8'd0, 32'h1000_0000));
         chk("t2_c1", cmds[1], cmd(8'd1, 32'h1000_0028));
         chk("t2_c2", cmds[2], cmd(8'd2, 32'h1000_0000));
         chk("t2_c3", cmds[3], cmd(8'd3, 32'h1000_0028));
      end
      repeat (4) pulse_done();
      tick();
      chk("t2_pdone", packets_done, 4);
      chk("t2_irq_cnt", irq_cnt, 1);
      chk("t2_idle", state, 0);

      // Backpressure, outstanding limit, then stop with a later boundary
      clr_mon();
      num_packets = 32'd0; ring_packets = 16'd0; tready = 1'b0;
      pulse_start();
      tick(); tick();
      chk("t3_tv", tvalid, 1);
      chk("t3_td", tdata, cmd(8'd0, 32'h1000_0000));
      repeat (5) tick();
      chk("t3_tv_hold", tvalid, 1);
      chk("t3_td_hold", tdata, cmd(8'd0, 32'h1000_0000));
      tready = 1'b1;
      repeat (6) tick();
      chk("t3_nmax", cmds.size(), 4);
      chk("t3_tv_lim", tvalid, 0);
      pulse_done();
      tick(); tick();
      chk("t3_nplus1", cmds.size(), 5);
      if (cmds.size() == 5) chk("t3_c4", cmds[4], cmd(8'd4, 32'h1000_00A0));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t4_drain", state, 3);
      chk("t4_cfg", pkt_config, 10);
      repeat (4) tick();
      pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
      chk("t4_done_st", state, 5);
      tick();
      chk("t4_drain_cyc", drain_cycles, 5);
      chk("t4_no_flush", flush_cycles, 0);
      chk("t4_irq_cnt", irq_cnt, 1);
      chk("t4_pdone", packets_done, 2);

      // Stop with no boundary: drain timeout then flush
      clr_mon();
      pulse_start();
      repeat (8) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      for (int i = 0; i < 1200 && state != 3'd0; i++) tick();
      chk("t5_idle", state, 0);
      chk("t5_drain_cyc", drain_cycles, 1024);
      chk("t5_flush_cyc", flush_cycles, 1);
      chk("t5_flush_out", flush_ok, 1);
      chk("t5_irq_cnt", irq_cnt, 1);

      // Zero length start is ignored
      packet_len = 16'd0;
      pulse_start();
      chk("t6_len0_st", state, 0);
      tick();
      chk("t6_len0_busy", busy, 0);

      // Asynchronous reset during RUN with a command pending
      packet_len = 16'd10; tready = 1'b0;
      pulse_start();
      tick(); tick();
      chk("t7_run", state, 2);
      #2 aresetn = 1'b0;
      #1;
      chk("t7_state", state, 0);
      chk("t7_cfg", pkt_config, 0);
      chk("t7_prstn", pkt_resetn, 0);
      chk("t7_tvalid", tvalid, 0);
      chk("t7_tdata", tdata, 0);
      chk("t7_busy", busy, 0);
      chk("t7_pdone", packets_done, 0);
      chk("t7_err", err, 0);
      tick();
      aresetn = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/packetizer_seq.md
# packetizer_seq

Acquisition sequencer for the ADC packetizer S2MM path. It programs the packetizer's length register and brackets each acquisition with a packetizer reset. It issues one DMA S2MM command per packet into a ring buffer, counts completed packets, and raises an interrupt on completion or stop. It sits between the software register bank and the packetizer/DataMover pair.

## Interface
Parameters:
- MAX_OUTSTANDING, 4 — maximum commands issued but not yet completed (1..255)
- DRAIN_TIMEOUT, 1024 — cycles to wait for a packet boundary after stop

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins an acquisition
- stop  in  1  one-cycle pulse; ends an acquisition early
- packet_len  in  16  packet length in 32-bit words; latched on start
- num_packets  in  32  packets per acquisition; 0 = continuous; latched on start
- base_addr  in  32  ring buffer base byte address; latched on start
- ring_packets  in  16  ring size in packets; 0 = no wrap; latched on start
- pkt_config  out  32  packetizer length register; 0 disables it
- pkt_resetn  out  1  packetizer active-low reset
- pkt_done  in  1  one-cycle pulse per accepted tlast beat from the packetizer
- m_axis_cmd_tdata  out  64  DMA command: [31:0] address, [55:32] byte count, [63:56] tag
- m_axis_cmd_tvalid  out  1  command valid
- m_axis_cmd_tready  in  1  command ready
- busy  out  1  high in any state other than IDLE
- irq  out  1  one-cycle pulse on entry to DONE
- packets_done  out  32  completed packets in the current or last acquisition
- err  out  1  sticky; set when pkt_done arrives with outstanding = 0; cleared by accepted start
- state  out  3  IDLE=0, ARM=1, RUN=2, DRAIN=3, FLUSH=4, DONE=5

## Operation
- All outputs are registered.
- Reset values: state=IDLE, pkt_config=0, pkt_resetn=0, tvalid=0, tdata=0, busy=0, irq=0, packets_done=0, err=0, all counters 0.
- IDLE: pkt_config=0, pkt_resetn=0.
  - start with packet_len≠0 → ARM. The block latches the parameters, clears packets_done, the issued count, the slot index and err.
  - start with packet_len=0 is ignored. stop is ignored in IDLE.
- ARM: exactly 2 cycles with pkt_resetn=0 and pkt_config=0, then → RUN.
- RUN: pkt_resetn=1, pkt_config = zero-extended latched packet_len.
  - A command is offered when outstanding (issued − done) < MAX_OUTSTANDING and, if num_packets≠0, issued < num_packets.
  - Command address = base_addr + slot × packet_len × 4, computed mod 2^32.
  - Command byte count = packet_len × 4. Tag = issued[7:0].
  - On accept: issued+1; slot+1, wrapping to 0 when slot+1 = ring_packets (ring_packets≠0). With ring_packets=0 there is no wrap.
  - pkt_done increments packets_done.
  - num_packets≠0 and packets_done reaching num_packets → DONE.
  - stop → DRAIN.
- DRAIN: no new commands are offered, and pkt_config stays set.
  - A pending command (tvalid=1) is held until accepted and counts as issued.
  - First pkt_done, or outstanding=0 → DONE.
  - DRAIN_TIMEOUT cycles elapsed → FLUSH.
- FLUSH: 1 cycle, pkt_resetn=0, pkt_config=0 → DONE. Only entered once no command is pending.
- DONE: 1 cycle, irq=1, pkt_config=0 → IDLE. packets_done holds its value until the next start.
- AXI-Stream rule: once tvalid=1, tdata and tvalid hold until tready=1, in every state.

## Timing
- start sampled at edge 0 → state=ARM from edge 1. pkt_resetn goes high and pkt_config and state=RUN are valid from edge 3.
- First command is valid from edge 3.
- Command throughput: 1 per cycle with tready held high. A new tdata follows each accept with no bubble.
- Accept and pkt_done in the same cycle: outstanding is unchanged, and both counters update.
- stop and the final pkt_done in the same cycle in RUN: → DONE; completion wins.
- start while busy: ignored.
- packets_done and issued wrap mod 2^32 in continuous mode.
- Asynchronous reset mid-acquisition: immediate return to reset values. Any pending command is dropped.

## Test plan
- packet_len=10, num_packets=3, base_addr=0x1000_0000, ring_packets=0, tready=1 → 3 commands at 0x1000_0000, 0x1000_0028, 0x1000_0050 with byte count 40 and tags 0,1,2; after 3 pkt_done pulses, irq for 1 cycle and packets_done=3.
- Same setup with 4 commands per acquisition and ring_packets=2 → addresses 0x1000_0000, 0x1000_0028, 0x1000_0000, 0x1000_0028.
- tready=0 and num_packets=0 → tvalid stuck high with tdata stable; tready=1 → exactly MAX_OUTSTANDING=4 commands accepted; one pkt_done → exactly 1 more command.
- stop in RUN, pkt_done 5 cycles later → DRAIN for 5 cycles, then DONE, irq, no FLUSH.
- stop with no pkt_done → FLUSH after 1024 cycles with pkt_resetn=0 for 1 cycle, then DONE and irq.
- pkt_done while IDLE → err=1; start with packet_len=0 → stays IDLE; aresetn low during RUN → every output equals its reset value on the next sample.
